mem_access: RTL and testbench

- Memory stage that sits directly downstream of the execute stage, behind the ex/mem pipeline register.
- Non-memory results pass through with 1-cycle latency.
- Loads and stores run as multi-cycle req/ack transactions on the data bus. Load data is extracted and extended here.
- Upstream is stalled while a transaction is outstanding. The result is presented to the mem/wb register.

---
 rtl/mem_access_pkg.sv | 39 +++
 rtl/mem_lane_align.sv | 85 ++++++++
 rtl/mem_access.sv | 138 +++++++++++++
 tb/tb_mem_access.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: memory aluop codes, bus widths,
// FSM states and big-endian byte-lane select patterns.
package mem_access_pkg;

    localparam int REG_BUS_W  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 8;

    localparam logic [ALUOP_W-1:0] OP_LB  = 8'he0;
    localparam logic [ALUOP_W-1:0] OP_LH  = 8'he1;
    localparam logic [ALUOP_W-1:0] OP_LW  = 8'he3;
    localparam logic [ALUOP_W-1:0] OP_LBU = 8'he4;
    localparam logic [ALUOP_W-1:0] OP_LHU = 8'he5;
    localparam logic [ALUOP_W-1:0] OP_SB  = 8'he8;
    localparam logic [ALUOP_W-1:0] OP_SH  = 8'he9;
    localparam logic [ALUOP_W-1:0] OP_SW  = 8'heb;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    // Lane 0 is the most significant byte (big-endian).
    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_B0   = 4'b1000;
    localparam logic [3:0] SEL_B1   = 4'b0100;
    localparam logic [3:0] SEL_B2   = 4'b0010;
    localparam logic [3:0] SEL_B3   = 4'b0001;
    localparam logic [3:0] SEL_H0   = 4'b1100;
    localparam logic [3:0] SEL_H1   = 4'b0011;
    localparam logic [3:0] SEL_W    = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: decodes the memory op, produces lane selects,
// replicated store data, the misalignment flag and the extended load result.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [ALUOP_W-1:0]   aluop,
    input  logic [1:0]           addr_lo,
    input  logic [REG_BUS_W-1:0] store_data,
    input  logic [REG_BUS_W-1:0] rdata,
    output logic                 is_mem,
    output logic                 is_load,
    output logic                 misalign,
    output logic [3:0]           sel,
    output logic [REG_BUS_W-1:0] wdata,
    output logic [REG_BUS_W-1:0] load_data
);

    size_t      size;
    logic       sign_ld;
    logic [7:0] byte_v;
    logic [15:0] half_v;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        is_mem  = 1'b0;
        is_load = 1'b0;
        sign_ld = 1'b0;
        size    = SZ_WORD;
        case (aluop)
            OP_LB:  begin is_mem = 1'b1; is_load = 1'b1; sign_ld = 1'b1; size = SZ_BYTE; end
            OP_LBU: begin is_mem = 1'b1; is_load = 1'b1;                 size = SZ_BYTE; end
            OP_LH:  begin is_mem = 1'b1; is_load = 1'b1; sign_ld = 1'b1; size = SZ_HALF; end
            OP_LHU: begin is_mem = 1'b1; is_load = 1'b1;                 size = SZ_HALF; end
            OP_LW:  begin is_mem = 1'b1; is_load = 1'b1;                 size = SZ_WORD; end
            OP_SB:  begin is_mem = 1'b1;                                 size = SZ_BYTE; end
            OP_SH:  begin is_mem = 1'b1;                                 size = SZ_HALF; end
            OP_SW:  begin is_mem = 1'b1;                                 size = SZ_WORD; end
            default: ;
        endcase
    end

    always_comb begin
        case (addr_lo)
            2'd0:    byte_v = rdata[31:24];
            2'd1:    byte_v = rdata[23:16];
            2'd2:    byte_v = rdata[15:8];
            default: byte_v = rdata[7:0];
        endcase
        half_v = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        misalign  = 1'b0;
        sel       = SEL_NONE;
        wdata     = store_data;
        load_data = rdata;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0:    sel = SEL_B0;
                    2'd1:    sel = SEL_B1;
                    2'd2:    sel = SEL_B2;
                    default: sel = SEL_B3;
                endcase
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{sign_ld & byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                misalign  = addr_lo[0];
                sel       = addr_lo[1] ? SEL_H1 : SEL_H0;
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{sign_ld & half_v[15]}}, half_v};
            end
            default: begin
                misalign = (addr_lo != 2'd0);
                sel      = SEL_W;
            end
        endcase
        if (!is_mem) begin
            misalign = 1'b0;
            sel      = SEL_NONE;
        end
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage: passes ALU results through in one cycle and runs loads/stores as
// req/ack bus transactions, stalling upstream until the transaction finishes or aborts.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [ALUOP_W-1:0]    aluop_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [REG_BUS_W-1:0]  wdata_i,
    input  logic [REG_BUS_W-1:0]  mem_addr_i,
    input  logic [REG_BUS_W-1:0]  mem_data_i,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [REG_BUS_W-1:0]  bus_addr_o,
    output logic [3:0]            bus_sel_o,
    output logic [REG_BUS_W-1:0]  bus_wdata_o,
    input  logic                  bus_ack_i,
    input  logic [REG_BUS_W-1:0]  bus_rdata_i,
    input  logic                  bus_err_i,
    output logic                  valid_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_BUS_W-1:0]  wdata_o,
    output logic                  exc_o,
    output logic                  stallreq_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 is_mem;
    logic                 is_load;
    logic                 misalign;
    logic [3:0]           lane_sel;
    logic [REG_BUS_W-1:0] lane_wdata;
    logic [REG_BUS_W-1:0] load_data;
    logic                 timeout;
    logic                 start_bus;
    logic                 bus_done;

    mem_lane_align u_lane_align (
        .aluop      (aluop_i),
        .addr_lo    (mem_addr_i[1:0]),
        .store_data (mem_data_i),
        .rdata      (bus_rdata_i),
        .is_mem     (is_mem),
        .is_load    (is_load),
        .misalign   (misalign),
        .sel        (lane_sel),
        .wdata      (lane_wdata),
        .load_data  (load_data)
    );

    assign timeout   = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign start_bus = valid_i && is_mem && !misalign;
    assign bus_done  = bus_ack_i | bus_err_i | timeout;

    // Gated by rst so the stall drops in the same instant the reset is applied.
    assign stallreq_o = rst && (((state == ST_IDLE) && start_bus) ||
                                ((state == ST_BUSY) && !bus_done));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_sel_o   <= SEL_NONE;
            bus_wdata_o <= '0;
            valid_o     <= 1'b0;
            wd_o        <= '0;
            wreg_o      <= 1'b0;
            wdata_o     <= '0;
            exc_o       <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults here make valid_o/exc_o single-cycle pulses;
            // a later assignment in the same block overrides them.
            valid_o <= 1'b0;
            exc_o   <= 1'b0;
            wreg_o  <= 1'b0;
            wd_o    <= '0;
            wdata_o <= '0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (valid_i) begin
                        if (!is_mem) begin
                            valid_o <= 1'b1;
                            wd_o    <= wd_i;
                            wreg_o  <= wreg_i;
                            wdata_o <= wdata_i;
                        end else if (misalign) begin
                            valid_o <= 1'b1;
                            exc_o   <= 1'b1;
                            wd_o    <= wd_i;
                        end else begin
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= !is_load;
                            bus_addr_o  <= {mem_addr_i[REG_BUS_W-1:2], 2'b00};
                            bus_sel_o   <= lane_sel;
                            bus_wdata_o <= lane_wdata;
                            state       <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt != '1) cnt <= cnt + 1'b1;
                    if (bus_done) begin
                        bus_req_o   <= 1'b0;
                        bus_we_o    <= 1'b0;
                        bus_addr_o  <= '0;
                        bus_sel_o   <= SEL_NONE;
                        bus_wdata_o <= '0;
                        valid_o     <= 1'b1;
                        wd_o        <= wd_i;
                        state       <= ST_IDLE;
                        // Ack wins over a coincident error or timeout.
                        if (bus_ack_i) begin
                            wreg_o  <= wreg_i;
                            wdata_o <= is_load ? load_data : wdata_i;
                        end else begin
                            exc_o <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, randomized ops against a
// byte-offset reference model, and hand sequences for reset and back-to-back issue.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [7:0]  aluop_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_i;
    logic        valid_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        exc_o;
    logic        stallreq_o;

    mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i), .wd_i(wd_i),
        .wreg_i(wreg_i), .wdata_i(wdata_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
        .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i), .valid_o(valid_o), .wd_o(wd_o),
        .wreg_o(wreg_o), .wdata_o(wdata_o), .exc_o(exc_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] OP_OR = 8'h25;

    typedef enum int {R_ACK, R_ERR, R_BOTH, R_NONE} resp_e;

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [31:0] wdata;
        resp_e       kind;
        int          n;
        logic [31:0] exp_wdata;
        logic        exp_exc;
        logic [3:0]  exp_sel;
        int          exp_busy;
    } vec_t;

    typedef struct {
        logic        exc;
        logic        wreg;
        logic [31:0] wdata;
        int          busy;
        logic [3:0]  sel;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic        we;
    } exp_t;

    int checks = 0;
    int errors = 0;

    // Observations from the most recent run_op.
    logic        o_valid, o_exc, o_wreg, o_we, o_stall_issue, o_stall_b1, o_stable, o_valid_after;
    logic [4:0]  o_wd;
    logic [31:0] o_wdata, o_addr, o_bwdata;
    logic [3:0]  o_sel;
    int          o_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int op_size(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit op_load(input logic [7:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic bit op_signed(input logic [7:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

    // Reference: byte offset within the word, lane i = bits [31-8i -: 8].
    function automatic exp_t model(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                                   input logic [31:0] rdata, input logic wreg, input logic [31:0] wdata,
                                   input resp_e kind, input int n);
        exp_t   e;
        int     size;
        int     off;
        longint mask;
        longint v;
        e.exc = 0; e.wreg = 0; e.wdata = 0; e.busy = 0; e.sel = 0; e.baddr = 0; e.bwdata = 0; e.we = 0;
        size = op_size(op);
        if (size == 0) begin
            e.wreg = wreg; e.wdata = wdata;
            return e;
        end
        off = int'(addr[1:0]);
        if (off % size != 0) begin
            e.exc = 1;
            return e;
        end
        e.baddr = addr - 32'(off);
        e.we    = !op_load(op);
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + size) e.sel[3-i] = 1'b1;
        mask = (64'd1 << (size * 8)) - 1;
        for (int i = 0; i < 4 / size; i++)
            e.bwdata = e.bwdata | 32'((longint'(sdata) & mask) << (i * size * 8));
        if (kind == R_NONE || n > TMO) begin
            e.busy = TMO; e.exc = 1;
            return e;
        end
        e.busy = n;
        if (kind == R_ERR) begin
            e.exc = 1;
            return e;
        end
        e.wreg = wreg;
        if (op_load(op)) begin
            v = (longint'(rdata) >> ((4 - off - size) * 8)) & mask;
            if (op_signed(op) && v[size*8-1]) v = v | ~mask;
            e.wdata = 32'(v);
        end else begin
            e.wdata = wdata;
        end
        return e;
    endfunction

    // Acts as upstream (holds inputs while stalled) and as the bus responder.
    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input logic [4:0] wd, input logic wreg,
                          input logic [31:0] wdata, input resp_e kind, input int n);
        @(negedge clk);
        valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; mem_data_i = sdata;
        wd_i = wd; wreg_i = wreg; wdata_i = wdata; bus_ack_i = 1'b0; bus_err_i = 1'b0;
        o_valid = 0; o_exc = 0; o_wreg = 0; o_wd = 0; o_wdata = 0; o_busy = 0;
        o_sel = 0; o_addr = 0; o_bwdata = 0; o_we = 0; o_stable = 1; o_stall_b1 = 0;
        #1 o_stall_issue = stallreq_o;
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = $urandom;
            if (valid_o) begin
                o_valid = 1; o_exc = exc_o; o_wreg = wreg_o; o_wd = wd_o; o_wdata = wdata_o;
                break;
            end
            if (bus_req_o) begin
                o_busy++;
                if (o_busy == 1) begin
                    o_sel = bus_sel_o; o_addr = bus_addr_o; o_bwdata = bus_wdata_o; o_we = bus_we_o;
                end else if (bus_sel_o !== o_sel || bus_addr_o !== o_addr ||
                             bus_wdata_o !== o_bwdata || bus_we_o !== o_we) begin
                    o_stable = 0;
                end
                if (o_busy == n && kind != R_NONE) begin
                    bus_ack_i = (kind == R_ACK || kind == R_BOTH);
                    bus_err_i = (kind == R_ERR || kind == R_BOTH);
                    bus_rdata_i = rdata;
                end
                if (o_busy == 1) #1 o_stall_b1 = stallreq_o;
            end
        end
        valid_i = 1'b0; bus_ack_i = 1'b0; bus_err_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        o_valid_after = valid_o;
    endtask

    task automatic check_op(input string name, input logic [7:0] op, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [31:0] rdata, input logic [4:0] wd,
                            input logic [31:0] wdata, input resp_e kind, input int n);
        exp_t e;
        e = model(op, addr, sdata, rdata, 1'b1, wdata, kind, n);
        run_op(op, addr, sdata, rdata, wd, 1'b1, wdata, kind, n);
        check({name, " valid"}, o_valid, 1);
        check({name, " exc"}, o_exc, e.exc);
        check({name, " wreg"}, o_wreg, e.wreg);
        check({name, " wdata"}, o_wdata, e.wdata);
        check({name, " busy"}, o_busy, e.busy);
        check({name, " sel"}, o_sel, e.sel);
        check({name, " stall_issue"}, o_stall_issue, e.sel != 0);
        check({name, " valid_pulse"}, o_valid_after, 0);
        if (!e.exc) check({name, " wd"}, o_wd, wd);
        if (e.sel != 0) begin
            check({name, " bus_addr"}, o_addr, e.baddr);
            check({name, " bus_wdata"}, o_bwdata, e.bwdata);
            check({name, " bus_we"}, o_we, e.we);
            check({name, " bus_stable"}, o_stable, 1);
            check({name, " stall_busy"}, o_stall_b1, !(n == 1 && kind != R_NONE));
        end
    endtask

    function automatic vec_t mkv(input string name, input logic [7:0] op, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic [31:0] rdata, input logic [31:0] wdata,
                                 input resp_e kind, input int n, input logic [31:0] exp_wdata,
                                 input logic exp_exc, input logic [3:0] exp_sel, input int exp_busy);
        vec_t v;
        v.name = name; v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.wdata = wdata;
        v.kind = kind; v.n = n; v.exp_wdata = exp_wdata; v.exp_exc = exp_exc; v.exp_sel = exp_sel;
        v.exp_busy = exp_busy;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[$];
        logic [7:0]  ops[9];
        logic [7:0]  rop;
        resp_e       rkind;

        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, OP_OR};

        vecs.push_back(mkv("pass_or",  OP_OR,  32'h0,   32'h0,    32'h0,        32'h0000F0F0, R_ACK,  1, 32'h0000F0F0, 0, 4'b0000, 0));
        vecs.push_back(mkv("lb_101",   OP_LB,  32'h101, 32'h0,    32'h11AA2233, 32'h0,        R_ACK,  3, 32'hFFFFFFAA, 0, 4'b0100, 3));
        vecs.push_back(mkv("lbu_101",  OP_LBU, 32'h101, 32'h0,    32'h11AA2233, 32'h0,        R_ACK,  3, 32'h000000AA, 0, 4'b0100, 3));
        vecs.push_back(mkv("sh_202",   OP_SH,  32'h202, 32'hBEEF, 32'h0,        32'h12345678, R_ACK,  2, 32'h12345678, 0, 4'b0011, 2));
        vecs.push_back(mkv("lw_mis",   OP_LW,  32'h103, 32'h0,    32'h0,        32'h77,       R_ACK,  1, 32'h0,        1, 4'b0000, 0));
        vecs.push_back(mkv("lh_mis",   OP_LH,  32'h101, 32'h0,    32'h0,        32'h77,       R_ACK,  1, 32'h0,        1, 4'b0000, 0));
        vecs.push_back(mkv("lw_err",   OP_LW,  32'h400, 32'h0,    32'h5,        32'h0,        R_ERR,  2, 32'h0,        1, 4'b1111, 2));
        vecs.push_back(mkv("lw_tmo",   OP_LW,  32'h500, 32'h0,    32'h5,        32'h0,        R_NONE, 0, 32'h0,        1, 4'b1111, 4));
        vecs.push_back(mkv("lh_both",  OP_LH,  32'h602, 32'h0,    32'h12348765, 32'h0,        R_BOTH, 1, 32'hFFFF8765, 0, 4'b0011, 1));
        vecs.push_back(mkv("lhu_600",  OP_LHU, 32'h600, 32'h0,    32'h80017FFF, 32'h0,        R_ACK,  1, 32'h00008001, 0, 4'b1100, 1));
        vecs.push_back(mkv("lb_003",   OP_LB,  32'h003, 32'h0,    32'h00000080, 32'h0,        R_ACK,  2, 32'hFFFFFF80, 0, 4'b0001, 2));
        vecs.push_back(mkv("sb_ack4",  OP_SB,  32'h001, 32'hA5,   32'h0,        32'hCAFE,     R_ACK,  4, 32'h0000CAFE, 0, 4'b0100, 4));
        vecs.push_back(mkv("sw_err4",  OP_SW,  32'h010, 32'h1,    32'h0,        32'h0,        R_ERR,  4, 32'h0,        1, 4'b1111, 4));

        rst = 1'b0; valid_i = 1'b1; aluop_i = OP_LW; wd_i = 5'd1; wreg_i = 1'b1;
        wdata_i = 32'hFFFF_FFFF; mem_addr_i = 32'h0; mem_data_i = 32'h0;
        bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = 32'h0;
        #12;
        check("reset bus_req", bus_req_o, 0);
        check("reset stallreq", stallreq_o, 0);
        check("reset valid", valid_o, 0);
        check("reset wdata", wdata_o, 0);
        check("reset sel", bus_sel_o, 0);
        @(negedge clk);
        valid_i = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            check_op(vecs[i].name, vecs[i].op, vecs[i].addr, vecs[i].sdata, vecs[i].rdata,
                     5'(i + 1), vecs[i].wdata, vecs[i].kind, vecs[i].n);
            check({vecs[i].name, " tbl_wdata"}, o_wdata, vecs[i].exp_wdata);
            check({vecs[i].name, " tbl_exc"}, o_exc, vecs[i].exp_exc);
            check({vecs[i].name, " tbl_sel"}, o_sel, vecs[i].exp_sel);
            check({vecs[i].name, " tbl_busy"}, o_busy, vecs[i].exp_busy);
        end
        check("sh_202 tbl_bus_wdata", vecs[3].exp_sel == 4'b0011 ? 32'hBEEFBEEF : 32'h0,
              model(OP_SH, 32'h202, 32'hBEEF, 0, 1, 0, R_ACK, 2).bwdata);

        for (int i = 0; i < 40; i++) begin
            rop = ops[$urandom_range(0, 8)];
            rkind = ($urandom_range(0, 7) == 0) ? R_NONE : resp_e'($urandom_range(0, 2));
            check_op($sformatf("rand%0d", i), rop, $urandom, $urandom, $urandom,
                     5'($urandom), $urandom, rkind, $urandom_range(1, 5));
        end

        // Reset asserted in the middle of a bus transaction.
        @(negedge clk);
        valid_i = 1'b1; aluop_i = OP_LW; mem_addr_i = 32'h800; wd_i = 5'd9; wreg_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst busy_req", bus_req_o, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst bus_req", bus_req_o, 0);
        check("midrst stallreq", stallreq_o, 0);
        check("midrst valid", valid_o, 0);
        @(negedge clk);
        valid_i = 1'b0;
        rst = 1'b1;
        check_op("after_rst", OP_OR, 32'h0, 32'h0, 32'h0, 5'd4, 32'h0BADF00D, R_ACK, 1);

        // Back-to-back: new op presented the cycle the store completes.
        @(negedge clk);
        valid_i = 1'b1; aluop_i = OP_SW; mem_addr_i = 32'h20; mem_data_i = 32'h600D;
        wd_i = 5'd2; wreg_i = 1'b0; wdata_i = 32'h0;
        @(posedge clk);
        @(negedge clk);
        check("b2b req", bus_req_o, 1);
        bus_ack_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_ack_i = 1'b0;
        check("b2b st_valid", valid_o, 1);
        check("b2b st_exc", exc_o, 0);
        aluop_i = OP_OR; wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'h55;
        #1 check("b2b stall", stallreq_o, 0);
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        check("b2b or_valid", valid_o, 1);
        check("b2b or_wdata", wdata_o, 32'h55);
        check("b2b or_wd", wd_o, 7);
        check("b2b or_req", bus_req_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
